// File: rtl/pow_pkg.sv
// Shared types and sizing for the power-unit result path.
package pow_pkg;
  localparam int POW_WIDTH  = 16;
  localparam int POW_DIGITS = 5;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_t;
endpackage

// File: rtl/pow_bcd_conv_if.sv
// Handshake bundle between the power unit, the BCD converter and the display driver.
interface pow_bcd_conv_if
  import pow_pkg::*;
#(
  parameter int WIDTH  = POW_WIDTH,
  parameter int DIGITS = POW_DIGITS
);
  logic                  in_valid;
  logic [WIDTH-1:0]      in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   bcd_digits;
  logic [DIGITS-1:0]     digit_en;
  logic                  busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, bcd_digits, digit_en, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, bcd_digits, digit_en, busy
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import pow_pkg::*;
(
  input  bcd_digit_t dig_i,
  output bcd_digit_t dig_o
);
  assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;
endmodule

// File: rtl/pow_bcd_conv.sv
// Sequential binary-to-BCD converter: one shift-add-3 iteration per cycle,
// result and leading-zero blanking mask held until the next operand is accepted.
module pow_bcd_conv
  import pow_pkg::*;
#(
  parameter int WIDTH  = POW_WIDTH,
  parameter int DIGITS = POW_DIGITS
)
(
  input  logic           clk,
  input  logic           rst_n,
  pow_bcd_conv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  conv_state_t         state_q;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] scr_q, scr_d, adj;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   en_q, en_d;
  logic [CW-1:0]       cnt_q;
  logic                out_vld_q, rdy_q, busy_q;
  logic                nz;
  logic                adj_msb_unused;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .dig_i (scr_q[4*g +: 4]),
      .dig_o (adj[4*g +: 4])
    );
  end

  // The top bit of the adjusted scratch is shifted out; it is always zero
  // because 10^DIGITS exceeds the largest input.
  assign scr_d          = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
  assign bin_d          = {bin_q[WIDTH-2:0], 1'b0};
  assign adj_msb_unused = adj[4*DIGITS-1];

  always_comb begin
    en_d = '0;
    nz   = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz      = nz | (scr_d[4*i +: 4] != 4'd0);
      en_d[i] = nz;
    end
    en_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scr_q     <= '0;
      bcd_q     <= '0;
      en_q      <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            bin_q     <= bus.in_data;
            scr_q     <= '0;
            cnt_q     <= CW'(WIDTH);
            out_vld_q <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q <= bin_d;
          scr_q <= scr_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q     <= scr_d;
            en_q      <= en_d;
            out_vld_q <= 1'b1;
            rdy_q     <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.busy       = busy_q;
  assign bus.out_valid  = out_vld_q;
  assign bus.bcd_digits = bcd_q;
  assign bus.digit_en   = en_q;
endmodule

// File: tb/tb_pow_bcd_conv.sv
// Scoreboard bench for pow_bcd_conv: directed vectors plus a random sweep against a decimal model.
module tb_pow_bcd_conv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic ov_prev = 1'b0;

  typedef struct {
    logic [15:0] v;
    logic [19:0] bcd;
    logic [4:0]  en;
    int          acc;
  } exp_t;
  exp_t sb[$];

  pow_bcd_conv_if bus ();

  pow_bcd_conv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_en(input logic [19:0] b);
    logic [4:0] e;
    logic [19:0] t;
    e = 5'b00001;
    for (int i = 1; i < 5; i++) begin
      t = b >> (4 * i);
      e[i] = (t != 20'd0);
    end
    return e;
  endfunction

  // Monitor: each rising out_valid is one completed conversion.
  always @(negedge clk) begin
    exp_t e;
    logic bad;
    if (rst_n && bus.out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {12'd0, bus.bcd_digits}, 32'hFFFFFFFF);
      end else begin
        e = sb.pop_front();
        chk("bcd_digits", {12'd0, bus.bcd_digits}, {12'd0, e.bcd});
        chk("digit_en", {27'd0, bus.digit_en}, {27'd0, e.en});
        chk("latency", 32'(cyc - e.acc), 32'd16);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) if (bus.bcd_digits[4*i +: 4] > 4'd9) bad = 1'b1;
        chk("digit_range", {31'd0, bad}, 32'd0);
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [15:0] v, input logic [19:0] eb, input logic [4:0] ee);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    sb.push_back('{v: v, bcd: eb, en: ee, acc: cyc + 1});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("ov_clear_on_accept", {31'd0, bus.out_valid}, 32'd0);
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    chk("rdy_after_accept", {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic chk_idle_reset();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_bcd", {12'd0, bus.bcd_digits}, 32'd0);
    chk("rst_en", {27'd0, bus.digit_en}, 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    int a;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    chk_idle_reset();
    rst_n = 1'b1;

    send(16'd0,     20'h00000, 5'b00001);
    send(16'd65535, 20'h65535, 5'b11111);
    send(16'd29791, 20'h29791, 5'b11111);
    send(16'd10,    20'h00010, 5'b00011);
    send(16'd9,     20'h00009, 5'b00001);
    send(16'd100,   20'h00100, 5'b00111);
    send(16'd40960, 20'h40960, 5'b11111);

    // 999 held valid throughout the 343 conversion; taken on the first IDLE edge.
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd343;
    sb.push_back('{v: 16'd343, bcd: 20'h00343, en: 5'b00111, acc: cyc + 1});
    @(posedge clk);
    #1;
    a = cyc;
    bus.in_data = 16'd999;
    sb.push_back('{v: 16'd999, bcd: 20'h00999, en: 5'b00111, acc: a + 17});
    repeat (8) @(posedge clk);
    #1;
    chk("busy_mid_shift", {31'd0, bus.busy}, 32'd1);
    repeat (9) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("held_accepted", {31'd0, bus.in_ready}, 32'd0);

    // Abort a conversion with reset at cycle 8.
    send(16'd12345, 20'h12345, 5'b11111);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    sb.delete(sb.size() - 1);
    @(negedge clk);
    chk_idle_reset();
    rst_n = 1'b1;
    send(16'd12345, 20'h12345, 5'b11111);

    for (int i = 0; i < 1000; i++) begin
      v = 16'($urandom_range(0, 65535));
      send(v, ref_bcd(int'(v)), ref_en(ref_bcd(int'(v))));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
